// File: rtl/pc_stage_tracker_pkg.sv
// Shared pipeline definitions for the per-stage PC tracker: bubble marker,
// stage numbering and the {pc, valid} stage record.
package pc_stage_tracker_pkg;

  localparam logic [7:0] BUBBLE_PC = 8'hFF;
  localparam int unsigned CNT_W = 16;

  // Encoding shared with the hazard state counter
  typedef enum logic [2:0] {
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

  typedef struct packed {
    logic [7:0] pc;
    logic       valid;
  } stage_t;

  localparam stage_t BUBBLE_REC = '{pc: BUBBLE_PC, valid: 1'b0};

endpackage

// File: rtl/pc_stage_tracker_if.sv
// Fetch/control inputs and per-stage PC/valid outputs of the PC stage tracker.
interface pc_stage_tracker_if;
  import pc_stage_tracker_pkg::*;

  logic [7:0]       pc_fetch;
  logic             fetch_valid;
  logic             stall;
  logic             flush;
  logic [7:0]       PC_nextID;
  logic [7:0]       PC_nextEX;
  logic [7:0]       PC_nextMEM;
  logic [7:0]       PC_nextWB;
  logic             valid_id;
  logic             valid_ex;
  logic             valid_mem;
  logic             valid_wb;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] retired;

  modport master (
    output pc_fetch, fetch_valid, stall, flush,
    input  PC_nextID, PC_nextEX, PC_nextMEM, PC_nextWB,
    input  valid_id, valid_ex, valid_mem, valid_wb, occupancy, retired
  );

  modport slave (
    input  pc_fetch, fetch_valid, stall, flush,
    output PC_nextID, PC_nextEX, PC_nextMEM, PC_nextWB,
    output valid_id, valid_ex, valid_mem, valid_wb, occupancy, retired
  );

endinterface

// File: rtl/pc_stage_reg.sv
// One pipeline stage {pc, valid} register; bubble beats hold beats load,
// and the PC output reads BUBBLE_PC whenever the stage is empty.
module pc_stage_reg
  import pc_stage_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       hold,
  input  logic       bubble,
  input  stage_t     dIn,
  output stage_t     q,
  output logic [7:0] pcOut
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE_REC;
    end else if (bubble) begin
      q <= BUBBLE_REC;
    end else if (load && !hold) begin
      q <= dIn.valid ? dIn : BUBBLE_REC;
    end
  end

  assign pcOut = q.valid ? q.pc : BUBBLE_PC;

endmodule

// File: rtl/pc_stage_tracker.sv
// Per-stage PC tracker for the IF->ID->EX->MEM->WB pipeline: stall/flush
// decode, four stage registers, retired counter and occupancy popcount.
module pc_stage_tracker
  import pc_stage_tracker_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  pc_stage_tracker_if.slave bus
);

  stage_t fetchRec;
  stage_t stId, stEx, stMem, stWb;
  logic   idBubble, idLoad, exBubble;
  logic [4:1] validVec;
  logic [CNT_W-1:0] retiredQ;

  assign fetchRec = '{pc: bus.pc_fetch, valid: bus.fetch_valid};

  // Flush outranks stall; a stall with no flush freezes ID and drops the fetch
  assign idBubble = bus.flush | (~bus.stall & ~bus.fetch_valid);
  assign idLoad   = bus.fetch_valid & ~bus.stall & ~bus.flush;
  assign exBubble = bus.flush | bus.stall;

  pc_stage_reg uId (
    .clk(clk), .rst_n(rst_n), .load(idLoad), .hold(bus.stall), .bubble(idBubble),
    .dIn(fetchRec), .q(stId), .pcOut(bus.PC_nextID)
  );

  pc_stage_reg uEx (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .hold(1'b0), .bubble(exBubble),
    .dIn(stId), .q(stEx), .pcOut(bus.PC_nextEX)
  );

  pc_stage_reg uMem (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .hold(1'b0), .bubble(1'b0),
    .dIn(stEx), .q(stMem), .pcOut(bus.PC_nextMEM)
  );

  pc_stage_reg uWb (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .hold(1'b0), .bubble(1'b0),
    .dIn(stMem), .q(stWb), .pcOut(bus.PC_nextWB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredQ <= '0;
    end else if (stWb.valid) begin
      retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  assign validVec[STG_ID]  = stId.valid;
  assign validVec[STG_EX]  = stEx.valid;
  assign validVec[STG_MEM] = stMem.valid;
  assign validVec[STG_WB]  = stWb.valid;

  assign bus.valid_id  = stId.valid;
  assign bus.valid_ex  = stEx.valid;
  assign bus.valid_mem = stMem.valid;
  assign bus.valid_wb  = stWb.valid;
  assign bus.occupancy = 3'($countones(validVec));
  assign bus.retired   = retiredQ;

endmodule

// File: tb/tb_pc_stage_tracker.sv
// Directed bench for pc_stage_tracker: streaming, stall, flush, stall+flush,
// asynchronous reset and retired-counter wrap.
module tb_pc_stage_tracker;
  import pc_stage_tracker_pkg::*;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  pc_stage_tracker_if bus ();

  pc_stage_tracker dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.pc_fetch    = 8'h00;
    bus.fetch_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic runFlush(input string pre, input logic withStall);
    doReset();
    bus.fetch_valid = 1'b1;
    bus.pc_fetch = 8'h30;
    step();
    bus.pc_fetch = 8'h31;
    step();
    checkVal({pre, "_pre_ex"}, 32'(bus.PC_nextEX), 32'h30);
    checkVal({pre, "_pre_id"}, 32'(bus.PC_nextID), 32'h31);
    bus.pc_fetch = 8'h32;
    bus.flush = 1'b1;
    bus.stall = withStall;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.fetch_valid = 1'b0;
    checkVal({pre, "_mem"}, 32'(bus.PC_nextMEM), 32'h30);
    checkVal({pre, "_ex"}, 32'(bus.PC_nextEX), 32'(BUBBLE_PC));
    checkVal({pre, "_id"}, 32'(bus.PC_nextID), 32'(BUBBLE_PC));
    checkVal({pre, "_vid"}, 32'(bus.valid_id), 32'h0);
    checkVal({pre, "_occ"}, 32'(bus.occupancy), 32'd1);
    step();
    checkVal({pre, "_wb"}, 32'(bus.PC_nextWB), 32'h30);
    checkVal({pre, "_mem2"}, 32'(bus.PC_nextMEM), 32'(BUBBLE_PC));
    repeat (4) step();
    checkVal({pre, "_ret"}, 32'(bus.retired), 32'd1);
    checkVal({pre, "_occ_end"}, 32'(bus.occupancy), 32'd0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    doReset();

    // reset state
    checkVal("rst_vid", 32'(bus.valid_id), 32'h0);
    checkVal("rst_vwb", 32'(bus.valid_wb), 32'h0);
    checkVal("rst_pcid", 32'(bus.PC_nextID), 32'hFF);
    checkVal("rst_pcwb", 32'(bus.PC_nextWB), 32'hFF);
    checkVal("rst_occ", 32'(bus.occupancy), 32'd0);
    checkVal("rst_ret", 32'(bus.retired), 32'd0);

    // streaming
    bus.fetch_valid = 1'b1;
    bus.pc_fetch = 8'h10;
    step();
    checkVal("str_id1", 32'(bus.PC_nextID), 32'h10);
    checkVal("str_ex1", 32'(bus.PC_nextEX), 32'hFF);
    bus.pc_fetch = 8'h11;
    step();
    checkVal("str_ex2", 32'(bus.PC_nextEX), 32'h10);
    checkVal("str_id2", 32'(bus.PC_nextID), 32'h11);
    bus.pc_fetch = 8'h12;
    step();
    checkVal("str_mem3", 32'(bus.PC_nextMEM), 32'h10);
    checkVal("str_occ3", 32'(bus.occupancy), 32'd3);
    bus.pc_fetch = 8'h13;
    step();
    checkVal("str_wb4", 32'(bus.PC_nextWB), 32'h10);
    checkVal("str_occ4", 32'(bus.occupancy), 32'd4);
    checkVal("str_ret4", 32'(bus.retired), 32'd0);
    bus.pc_fetch = 8'h14;
    step();
    checkVal("str_ret5", 32'(bus.retired), 32'd1);
    checkVal("str_wb5", 32'(bus.PC_nextWB), 32'h11);
    checkVal("str_id5", 32'(bus.PC_nextID), 32'h14);

    // stall for two cycles with 8'h20 in ID
    doReset();
    bus.fetch_valid = 1'b1;
    bus.pc_fetch = 8'h20;
    step();
    checkVal("stl_id1", 32'(bus.PC_nextID), 32'h20);
    bus.stall = 1'b1;
    bus.pc_fetch = 8'h21;
    step();
    checkVal("stl_id2", 32'(bus.PC_nextID), 32'h20);
    checkVal("stl_ex2", 32'(bus.PC_nextEX), 32'hFF);
    step();
    checkVal("stl_id3", 32'(bus.PC_nextID), 32'h20);
    checkVal("stl_ex3", 32'(bus.PC_nextEX), 32'hFF);
    checkVal("stl_vex3", 32'(bus.valid_ex), 32'h0);
    bus.stall = 1'b0;
    step();
    checkVal("stl_ex4", 32'(bus.PC_nextEX), 32'h20);
    checkVal("stl_id4", 32'(bus.PC_nextID), 32'h21);
    bus.fetch_valid = 1'b0;
    step();
    checkVal("stl_wb5", 32'(bus.PC_nextWB), 32'hFF);
    step();
    checkVal("stl_wb6", 32'(bus.PC_nextWB), 32'h20);

    // flush alone, then stall+flush together
    runFlush("fl", 1'b0);
    runFlush("sf", 1'b1);

    // asynchronous reset with all stages full
    doReset();
    bus.fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.pc_fetch = 8'(8'h50 + i);
      step();
    end
    checkVal("ar_occ_full", 32'(bus.occupancy), 32'd4);
    checkVal("ar_ret_pre", 32'(bus.retired), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("ar_vid", 32'(bus.valid_id), 32'h0);
    checkVal("ar_vex", 32'(bus.valid_ex), 32'h0);
    checkVal("ar_vmem", 32'(bus.valid_mem), 32'h0);
    checkVal("ar_vwb", 32'(bus.valid_wb), 32'h0);
    checkVal("ar_pcid", 32'(bus.PC_nextID), 32'hFF);
    checkVal("ar_pcex", 32'(bus.PC_nextEX), 32'hFF);
    checkVal("ar_pcmem", 32'(bus.PC_nextMEM), 32'hFF);
    checkVal("ar_pcwb", 32'(bus.PC_nextWB), 32'hFF);
    checkVal("ar_ret", 32'(bus.retired), 32'd0);
    checkVal("ar_occ", 32'(bus.occupancy), 32'd0);
    rst_n = 1'b1;
    bus.pc_fetch = 8'h40;
    step();
    checkVal("ar_first_id", 32'(bus.PC_nextID), 32'h40);
    checkVal("ar_first_ex", 32'(bus.PC_nextEX), 32'hFF);

    // retired wraps: tight loop on one PC, 65539 edges leaves retired=FFFF
    doReset();
    bus.fetch_valid = 1'b1;
    bus.pc_fetch = 8'h40;
    repeat (65539) step();
    checkVal("wrap_pre", 32'(bus.retired), 32'hFFFF);
    checkVal("wrap_vwb", 32'(bus.valid_wb), 32'h1);
    checkVal("wrap_loop_pc", 32'(bus.PC_nextMEM), 32'h40);
    step();
    checkVal("wrap_post", 32'(bus.retired), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pc_stage_tracker.md
# pc_stage_tracker

Tracks the program counter of every in-flight instruction as it moves through the five-stage pipeline (IF→ID→EX→MEM→WB). It is the producer of the per-stage PC buses that the hazard/state comparison logic consumes, and it applies the pipeline's stall, flush and bubble rules. It also keeps a retired-instruction count and a live occupancy count for debug.

## Interface
- BUBBLE_PC, 8'hFF: value driven on a stage PC bus while that stage holds no valid instruction; never a legal fetch address.
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_fetch  in  8  PC of the instruction leaving IF this cycle.
- fetch_valid  in  1  pc_fetch carries a real instruction.
- stall  in  1  load-use stall: hold ID, insert bubble into EX.
- flush  in  1  taken branch resolved in EX: squash ID and the incoming fetch.
- PC_nextID, PC_nextEX, PC_nextMEM, PC_nextWB  out  8 each  PC held in that stage, or BUBBLE_PC when invalid.
- valid_id, valid_ex, valid_mem, valid_wb  out  1 each  stage holds a valid instruction.
- occupancy  out  3  number of valid stages among ID..WB (0–4), combinational from the valid bits.
- retired  out  CNT_W  instructions that have completed WB since reset.

## Operation
- Each stage is a {pc, valid} register. A stage PC output is BUBBLE_PC whenever its valid bit is 0, so a bubble never equals a real PC.
- MEM and WB always advance:
  - WB ← MEM
  - MEM ← EX
- EX update:
  - If flush=1 or stall=1: EX ← bubble.
  - Otherwise: EX ← ID.
- ID update, in priority order:
  - flush=1: ID ← bubble (flush beats stall).
  - stall=1: ID holds its value; pc_fetch is ignored, and the fetch unit must re-present it.
  - fetch_valid=1: ID ← pc_fetch.
  - Otherwise: ID ← bubble.
- The branch that causes a flush sits in EX, so it still advances to MEM on the flush edge and is not squashed.
- retired increments by 1 on every edge where valid_wb=1 before the edge. It wraps from all-ones to 0 and has no saturation.
- Reset (rst_n=0, asynchronous):
  - all valid bits 0;
  - all stage PCs BUBBLE_PC;
  - retired 0;
  - occupancy 0.
- Reset asserted mid-stream discards all in-flight instructions immediately, without waiting for a clock edge.
- The first edge after reset deasserts samples pc_fetch normally.

## Timing
- Latency from pc_fetch to a stage output, with no stall or flush:
  - PC_nextID: 1 cycle
  - PC_nextEX: 2 cycles
  - PC_nextMEM: 3 cycles
  - PC_nextWB: 4 cycles
  - counted in retired: 5 cycles
- Each stall cycle adds 1 cycle of latency to instructions in ID and younger. Instructions already in EX or later are unaffected.
- All stage outputs are registered. occupancy is the only combinational output and depends on the valid bits only, never on inputs.
- Simultaneous stall=1 and flush=1: flush behaviour applies in full (ID and EX both become bubbles).
- A PC value repeating in consecutive stages (a tight loop) is legal. The tracker does no de-duplication.

## Structure
- Shared pipeline package holds:
  - BUBBLE_PC;
  - the stage enumeration (ID=1, EX=2, MEM=3, WB=4), matching the encoding used by the hazard state counter;
  - the {pc, valid} stage record type.
- One sub-module, pc_stage_reg: a single {pc, valid} register with load, hold and bubble controls and the BUBBLE_PC output mux. It is instantiated four times.
- The top level contains only the control decode, the retired counter and the occupancy popcount.

## Test plan
- Streaming: reset, then fetch_valid=1 with pc_fetch = 8'h10, 8'h11, 8'h12… on consecutive cycles → PC_nextWB=8'h10 at cycle 4, retired=1 at cycle 5, occupancy=4 from cycle 4.
- Stall: pc_fetch=8'h20 enters ID; stall=1 for 2 cycles → PC_nextID stays 8'h20 for 3 cycles, EX shows BUBBLE_PC for 2 cycles, 8'h20 reaches WB 2 cycles later than unstalled.
- Flush: 8'h30 in EX, 8'h31 in ID, pc_fetch=8'h32, flush=1 → next cycle MEM=8'h30, EX and ID both BUBBLE_PC, 8'h32 never appears; retired counts only 8'h30 of the three.
- Stall and flush together: stall=1, flush=1 in the same cycle → identical result to flush alone.
- Asynchronous reset: assert rst_n=0 between edges with all stages full → all valids 0, all PCs 8'hFF and retired 0 before the next edge.
- Counter wrap: preload via long run (or force) retired=16'hFFFF with valid_wb=1 → next edge retired=16'h0000.
